// File: rtl/uart_tx_io.sv
// ============================================================================
// Module      : uart_tx_io
// Description : Memory-mapped UART transmitter on the CPU IO bus. Bytes written
//               to DATA are queued in a FIFO and sent as 8N1 frames on tx.
//               Optional even parity (8E1) when UART_TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_io #(
    parameter int BAUD_DIV   = 2396,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        uartcs,
    input  logic        uartwrite,
    input  logic        uartread,
    input  logic [1:0]  uartaddr,
    input  logic [15:0] uart_wdata,
    output logic [15:0] uart_rdata,
    output logic        tx
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_BAUD_W = $clog2(BAUD_DIV);

    localparam logic [c_PTR_W:0]    c_DEPTH     = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]    c_CNT_ONE   = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(BAUD_DIV - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                r_state_q, w_state_d;
    logic [c_BAUD_W-1:0]   r_baud_q, w_baud_d;
    logic [2:0]            r_bit_q, w_bit_d;
    logic [7:0]            r_shift_q, w_shift_d;
    logic                  r_tx_q, w_tx_d;
    logic [c_PTR_W-1:0]    r_rd_ptr_q, w_rd_ptr_d;
    logic [c_PTR_W-1:0]    r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W:0]      r_count_q, w_count_d;
    logic                  r_ovf_q, w_ovf_d;
    logic [7:0]            r_mem [FIFO_DEPTH];

    logic w_push, w_push_ok, w_pop, w_stat_rd, w_full, w_busy, w_baud_last;
    logic w_unused_wdata;

`ifdef UART_TX_PARITY_EN
    logic r_par_q, w_par_d;
`endif

    assign w_unused_wdata = ^uart_wdata[15:8];

    // Bus decode and FIFO bookkeeping
    always_comb begin
        w_push    = uartcs & uartwrite & (uartaddr == 2'b00);
        w_stat_rd = uartcs & uartread  & (uartaddr == 2'b10);
        w_full    = (r_count_q == c_DEPTH);
        w_push_ok = w_push & ~w_full;
        w_pop     = (r_state_q == ST_IDLE) & (r_count_q != '0);
        w_busy    = (r_state_q != ST_IDLE) | (r_count_q != '0);

        w_wr_ptr_d = w_push_ok ? r_wr_ptr_q + c_PTR_ONE : r_wr_ptr_q;
        w_rd_ptr_d = w_pop     ? r_rd_ptr_q + c_PTR_ONE : r_rd_ptr_q;

        w_count_d = r_count_q;
        if (w_push_ok && !w_pop) begin
            w_count_d = r_count_q + c_CNT_ONE;
        end else if (!w_push_ok && w_pop) begin
            w_count_d = r_count_q - c_CNT_ONE;
        end

        // A dropped push in the same cycle as a status read keeps the flag set
        if (w_push && w_full) begin
            w_ovf_d = 1'b1;
        end else if (w_stat_rd) begin
            w_ovf_d = 1'b0;
        end else begin
            w_ovf_d = r_ovf_q;
        end

        uart_rdata = w_stat_rd ? {13'b0, r_ovf_q, w_full, w_busy} : 16'h0000;
    end

    // Transmit FSM; tx_d carries the level for the state being entered
    always_comb begin
        w_state_d   = r_state_q;
        w_baud_d    = r_baud_q;
        w_bit_d     = r_bit_q;
        w_shift_d   = r_shift_q;
        w_tx_d      = r_tx_q;
        w_baud_last = (r_baud_q == c_BAUD_LAST);
`ifdef UART_TX_PARITY_EN
        w_par_d     = r_par_q;
`endif

        if (r_state_q != ST_IDLE) begin
            w_baud_d = w_baud_last ? '0 : r_baud_q + c_BAUD_ONE;
        end

        case (r_state_q)
            ST_IDLE: begin
                w_tx_d = 1'b1;
                if (w_pop) begin
                    w_shift_d = r_mem[r_rd_ptr_q];
                    w_state_d = ST_START;
                    w_baud_d  = '0;
                    w_tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    w_par_d   = ^r_mem[r_rd_ptr_q];
`endif
                end
            end
            ST_START: begin
                if (w_baud_last) begin
                    w_state_d = ST_DATA;
                    w_bit_d   = 3'd0;
                    w_tx_d    = r_shift_q[0];
                end
            end
            ST_DATA: begin
                if (w_baud_last) begin
                    if (r_bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_d = ST_PARITY;
                        w_tx_d    = r_par_q;
`else
                        w_state_d = ST_STOP;
                        w_tx_d    = 1'b1;
`endif
                    end else begin
                        w_shift_d = {1'b0, r_shift_q[7:1]};
                        w_bit_d   = r_bit_q + 3'd1;
                        w_tx_d    = r_shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_baud_last) begin
                    w_state_d = ST_STOP;
                    w_tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (w_baud_last) begin
                    w_state_d = ST_IDLE;
                    w_tx_d    = 1'b1;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_baud_q   <= '0;
            r_bit_q    <= '0;
            r_shift_q  <= '0;
            r_tx_q     <= 1'b1;
            r_rd_ptr_q <= '0;
            r_wr_ptr_q <= '0;
            r_count_q  <= '0;
            r_ovf_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_baud_q   <= w_baud_d;
            r_bit_q    <= w_bit_d;
            r_shift_q  <= w_shift_d;
            r_tx_q     <= w_tx_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_count_q  <= w_count_d;
            r_ovf_q    <= w_ovf_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_par_q <= 1'b0;
        end else begin
            r_par_q <= w_par_d;
        end
    end
`endif

    // Storage needs no reset: validity is tracked by the pointers and count
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr_q] <= uart_wdata[7:0];
        end
    end

    assign tx = r_tx_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_io.sv
// ============================================================================
// Module      : tb_uart_tx_io
// Description : Directed bench for uart_tx_io with a small frame table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_io;

    localparam int BAUD  = 4;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BAUD;

    logic        clock = 1'b0;
    logic        rst   = 1'b0;
    logic        uartcs = 1'b0, uartwrite = 1'b0, uartread = 1'b0;
    logic [1:0]  uartaddr = 2'b00;
    logic [15:0] uart_wdata = 16'h0000;
    logic [15:0] uart_rdata;
    logic        tx;

    int total = 0;
    int bad   = 0;

    uart_tx_io #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .rst        (rst),
        .uartcs     (uartcs),
        .uartwrite  (uartwrite),
        .uartread   (uartread),
        .uartaddr   (uartaddr),
        .uart_wdata (uart_wdata),
        .uart_rdata (uart_rdata),
        .tx         (tx)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] d;
        logic [9:0] f8n1;   // {stop, data[7:0], start}, bit 0 sent first
        logic       par;
    } vec_t;

    typedef struct {
        logic [10:0] bits;
        bit          stable;
        int          gap;
    } frame_t;

    vec_t   vec [10];
    frame_t rxq [$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Line monitor: records each frame's bit levels, per-bit stability and preceding idle gap
    initial begin : monitor
        int gap;
        gap = 0;
        forever begin
            @(negedge clock);
            if (tx === 1'b1) begin
                gap++;
            end else begin
                frame_t r;
                r.bits = '0;
                r.stable = 1'b1;
                r.gap = gap;
                for (int k = 0; k < NBITS; k++) begin
                    for (int c = 0; c < BAUD; c++) begin
                        if (k != 0 || c != 0) @(negedge clock);
                        if (c == 0) r.bits[k] = tx;
                        else if (tx !== r.bits[k]) r.stable = 1'b0;
                    end
                end
                rxq.push_back(r);
                gap = 0;
            end
        end
    end

    task automatic bus_idle();
        uartcs = 1'b0; uartwrite = 1'b0; uartread = 1'b0;
        uartaddr = 2'b00; uart_wdata = 16'h0000;
    endtask

    task automatic bus_wr_raw(input logic cs, input logic [1:0] addr, input logic [7:0] d);
        uartcs = cs; uartwrite = 1'b1; uartread = 1'b0;
        uartaddr = addr; uart_wdata = {8'hC3, d};
        @(negedge clock);
        bus_idle();
    endtask

    task automatic bus_wr(input logic [7:0] d);
        bus_wr_raw(1'b1, 2'b00, d);
    endtask

    task automatic bus_rd(input logic cs, input logic [1:0] addr, output logic [15:0] v);
        uartcs = cs; uartwrite = 1'b0; uartread = 1'b1; uartaddr = addr;
        #1 v = uart_rdata;
        @(negedge clock);
        bus_idle();
    endtask

    task automatic rd_status(output logic [15:0] v);
        bus_rd(1'b1, 2'b10, v);
    endtask

    task automatic wait_frames(input int n, input int budget, input string nm);
        int c;
        c = 0;
        while (rxq.size() < n && c < budget) begin
            @(negedge clock);
            c++;
        end
        chk({nm, " frame count"}, rxq.size(), n);
    endtask

    task automatic check_frame(input int idx, input int vi, input bit chk_gap, input string nm);
        logic [10:0] exp;
        frame_t r;
        if (idx >= rxq.size()) return;
        r = rxq[idx];
`ifdef UART_TX_PARITY_EN
        exp = {1'b1, vec[vi].par, vec[vi].f8n1[8:0]};
`else
        exp = {1'b0, vec[vi].f8n1};
`endif
        chk($sformatf("%s frame%0d bits", nm, idx), r.bits, exp);
        chk($sformatf("%s frame%0d stable", nm, idx), r.stable, 1);
        if (chk_gap) chk($sformatf("%s frame%0d gap", nm, idx), r.gap, 1);
    endtask

    initial begin : main
        logic [15:0] v;
        int n;

        vec[0] = '{8'hA5, 10'b1_1010_0101_0, 1'b0};
        vec[1] = '{8'h07, 10'b1_0000_0111_0, 1'b1};
        vec[2] = '{8'h03, 10'b1_0000_0011_0, 1'b0};
        vec[3] = '{8'h00, 10'b1_0000_0000_0, 1'b0};
        vec[4] = '{8'hFF, 10'b1_1111_1111_0, 1'b0};
        vec[5] = '{8'h80, 10'b1_1000_0000_0, 1'b1};
        vec[6] = '{8'h01, 10'b1_0000_0001_0, 1'b1};
        vec[7] = '{8'h3C, 10'b1_0011_1100_0, 1'b0};
        vec[8] = '{8'h5A, 10'b1_0101_1010_0, 1'b0};
        vec[9] = '{8'hE6, 10'b1_1110_0110_0, 1'b1};

        // Reset state
        #1 rst = 1'b1;
        @(negedge clock);
        chk("reset tx", tx, 1);
        rd_status(v);
        chk("reset status", v, 16'h0000);
        rst = 1'b0;
        @(negedge clock);

        // Reset mid-frame: tx high at once, pending byte discarded
        bus_wr(8'hA5);
        bus_wr(8'h5A);
        chk("pre-reset tx low", tx, 0);
        #2 rst = 1'b1;
        #1 chk("reset mid-frame tx", tx, 1);
        @(negedge clock);
        rst = 1'b0;
        rd_status(v);
        chk("status after reset", v, 16'h0000);
        repeat (FRAME + 10) @(negedge clock);
        rxq.delete();
        repeat (FRAME + 10) @(negedge clock);
        chk("no frame after reset", rxq.size(), 0);

        // Single byte with cycle-exact busy window
        bus_wr(8'hA5);
        rd_status(v);
        chk("single busy start", v, 16'h0001);
        repeat (FRAME - 2) @(negedge clock);
        rd_status(v);
        chk("single busy late", v, 16'h0001);
        rd_status(v);
        chk("single busy last stop", v, 16'h0001);
        rd_status(v);
        chk("single idle after stop", v, 16'h0000);
        chk("single tx idle", tx, 1);
        wait_frames(1, 20, "single");
        check_frame(0, 0, 1'b0, "single");
        rxq.delete();

        // Nine back-to-back writes: second write meets the first pop, ninth fills the FIFO
        for (int i = 0; i < 9; i++) bus_wr(vec[i].d);
        rd_status(v);
        chk("burst9 full", v, 16'h0003);
        n = 0;
        while (v == 16'h0003 && n < FRAME + 20) begin
            rd_status(v);
            n++;
        end
        chk("full clears after pop", v, 16'h0001);
        wait_frames(9, 9 * (FRAME + 2) + 20, "burst9");
        for (int i = 0; i < 9; i++) check_frame(i, i, i > 0, "burst9");
        repeat (2) @(negedge clock);
        rd_status(v);
        chk("burst9 done status", v, 16'h0000);
        rxq.delete();

        // Ten writes in one burst: the last is dropped and overflow latches
        for (int i = 9; i >= 0; i--) bus_wr(vec[i].d);
        bus_rd(1'b0, 2'b10, v);
        chk("read with cs low", v, 16'h0000);
        bus_rd(1'b1, 2'b00, v);
        chk("read of DATA offset", v, 16'h0000);
        rd_status(v);
        chk("burst10 overflow", v, 16'h0007);
        rd_status(v);
        chk("overflow cleared", v, 16'h0003);
        wait_frames(9, 9 * (FRAME + 2) + 20, "burst10");
        for (int j = 0; j < 9; j++) check_frame(j, 9 - j, j > 0, "burst10");
        repeat (FRAME + 10) @(negedge clock);
        chk("burst10 dropped byte", rxq.size(), 9);
        rd_status(v);
        chk("burst10 done status", v, 16'h0000);
        rxq.delete();

        // Writes without chip select or to other offsets have no effect
        bus_wr_raw(1'b0, 2'b00, 8'h11);
        bus_wr_raw(1'b1, 2'b01, 8'h22);
        bus_wr_raw(1'b1, 2'b10, 8'h33);
        bus_wr_raw(1'b1, 2'b11, 8'h44);
        rd_status(v);
        chk("ignored writes status", v, 16'h0000);
        repeat (FRAME + 10) @(negedge clock);
        chk("ignored writes no frame", rxq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
